// File: rtl/cymo_meas_sched.sv
// Round-robin measurement scheduler for the frequency/phase meter core.
// Build macro CYM_SCHED_AVG_EN: sum 2^AVG_LOG2 measurements into each result.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start
// S_SELECT  | drive ch_sel to next enabled channel
// S_SETTLE  | let the clock mux settle for SETTLE_CYC cycles
// S_ARM     | meas_start pulse to the meter
// S_WAIT    | wait for meas_done or timeout
// S_CAPTURE | load result registers from capture registers
// S_OUTPUT  | hold result until res_ready
// S_DONE    | sweep_done pulse; restart when cont is set
module cymo_meas_sched #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 200_000_000,
    parameter int AVG_LOG2    = 2
) (
    input  logic                     clk_fs,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cont,
    input  logic [N_CH-1:0]          ch_mask,
    output logic                     busy,
    output logic                     sweep_done,
    output logic [$clog2(N_CH)-1:0]  ch_sel,
    output logic                     meas_start,
    input  logic                     meas_done,
    input  logic [CNT_W-1:0]         fs_cnt_p_i,
    input  logic [CNT_W-1:0]         fs_cnt_n_i,
    input  logic [CNT_W-1:0]         fx_cnt_i,
    input  logic [CNT_W-1:0]         fxy_cnt_i,
    input  logic                     px_i,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_CH)-1:0]  res_ch,
    output logic [CNT_W+7:0]         res_fs,
    output logic [CNT_W+7:0]         res_fx,
    output logic [CNT_W+7:0]         res_fxy,
    output logic                     res_px,
    output logic                     res_timeout
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int RES_W = CNT_W + 8;
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
`ifdef CYM_SCHED_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    localparam logic [7:0] REP_LAST = AVG_EN ? 8'((1 << AVG_LOG2) - 1) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_ARM, S_WAIT, S_CAPTURE, S_OUTPUT, S_DONE
    } state_t;

    state_t            state_q;
    logic [N_CH-1:0]   mask_q;
    logic              first_q;
    logic [CH_W-1:0]   ch_sel_q;
    logic [ST_W-1:0]   settle_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        rep_q;
    logic [RES_W-1:0]  cap_fs_q, cap_fx_q, cap_fxy_q;
    logic              cap_px_q, cap_tmo_q;
    logic              busy_q, sweep_done_q, meas_start_q;
    logic              res_valid_q, res_px_q, res_timeout_q;
    logic [CH_W-1:0]   res_ch_q;
    logic [RES_W-1:0]  res_fs_q, res_fx_q, res_fxy_q;

    logic              nxt_vld_d;
    logic [CH_W-1:0]   nxt_ch_d;

    // Lowest enabled channel above ch_sel, or the lowest overall at sweep start.
    always_comb begin
        nxt_vld_d = 1'b0;
        nxt_ch_d  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (first_q || i > int'(ch_sel_q))) begin
                nxt_vld_d = 1'b1;
                nxt_ch_d  = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk_fs) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            first_q       <= 1'b1;
            ch_sel_q      <= '0;
            settle_q      <= '0;
            tmo_q         <= '0;
            rep_q         <= '0;
            cap_fs_q      <= '0;
            cap_fx_q      <= '0;
            cap_fxy_q     <= '0;
            cap_px_q      <= 1'b0;
            cap_tmo_q     <= 1'b0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            meas_start_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_fs_q      <= '0;
            res_fx_q      <= '0;
            res_fxy_q     <= '0;
            res_px_q      <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            meas_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q  <= ch_mask;
                        first_q <= 1'b1;
                        if (ch_mask == '0) begin
                            sweep_done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    ch_sel_q  <= nxt_ch_d;
                    first_q   <= 1'b0;
                    settle_q  <= ST_W'(SETTLE_CYC - 1);
                    rep_q     <= '0;
                    cap_fs_q  <= '0;
                    cap_fx_q  <= '0;
                    cap_fxy_q <= '0;
                    cap_tmo_q <= 1'b0;
                    state_q   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        meas_start_q <= 1'b1;
                        state_q      <= S_ARM;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                S_ARM: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (meas_done) begin
                        // Without averaging the accumulators restart from zero each time.
                        cap_fs_q  <= (AVG_EN ? cap_fs_q : '0) + RES_W'(fs_cnt_p_i) + RES_W'(fs_cnt_n_i);
                        cap_fx_q  <= (AVG_EN ? cap_fx_q : '0) + RES_W'(fx_cnt_i);
                        cap_fxy_q <= (AVG_EN ? cap_fxy_q : '0) + RES_W'(fxy_cnt_i);
                        cap_px_q  <= px_i;
                        cap_tmo_q <= 1'b0;
                        if (rep_q == REP_LAST) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            rep_q        <= rep_q + 8'd1;
                            meas_start_q <= 1'b1;
                            state_q      <= S_ARM;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        cap_fs_q  <= '0;
                        cap_fx_q  <= '0;
                        cap_fxy_q <= '0;
                        cap_px_q  <= 1'b0;
                        cap_tmo_q <= 1'b1;
                        state_q   <= S_CAPTURE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    res_ch_q      <= ch_sel_q;
                    res_fs_q      <= cap_fs_q;
                    res_fx_q      <= cap_fx_q;
                    res_fxy_q     <= cap_fxy_q;
                    res_px_q      <= cap_px_q;
                    res_timeout_q <= cap_tmo_q;
                    res_valid_q   <= 1'b1;
                    state_q       <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (nxt_vld_d) begin
                            state_q <= S_SELECT;
                        end else begin
                            sweep_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (cont && ch_mask != '0) begin
                        mask_q  <= ch_mask;
                        first_q <= 1'b1;
                        state_q <= S_SELECT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign ch_sel      = ch_sel_q;
    assign meas_start  = meas_start_q;
    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_fs      = res_fs_q;
    assign res_fx      = res_fx_q;
    assign res_fxy     = res_fxy_q;
    assign res_px      = res_px_q;
    assign res_timeout = res_timeout_q;

endmodule
